// File: rtl/data_sync.sv
// Multi-flop bus synchronizer: bus_enable crosses through a flop chain, and its
// synchronized rising edge captures the quasi-static source bus. Adds valid/ack, overrun and a capture counter.
module data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 data_ack,
  input  logic                 ovr_clr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 data_valid,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] capture_count
);

  if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
    $error("data_sync: NUM_STAGES must be 2..4");
  end

  logic [NUM_STAGES-1:0] sync_stage_q, sync_stage_d;
  logic                  sync_en_d_q;
  logic                  sync_en;
  logic                  en_rise;

  logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
  logic                  pulse_q;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  assign sync_en      = sync_stage_q[NUM_STAGES-1];
  assign en_rise      = sync_en & ~sync_en_d_q;
  assign sync_stage_d = {sync_stage_q[NUM_STAGES-2:0], bus_enable};

  always_comb begin
    sync_bus_d = sync_bus_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;

    // A same-cycle ack retires the old word; the new one stays valid.
    if (en_rise) begin
      sync_bus_d = unsync_bus;
      valid_d    = 1'b1;
      cnt_d      = cnt_q + CNT_WIDTH'(1);
    end else if (data_ack) begin
      valid_d    = 1'b0;
    end

    if (en_rise && valid_q && !data_ack) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_stage_q <= '0;
      sync_en_d_q  <= 1'b0;
      sync_bus_q   <= '0;
      pulse_q      <= 1'b0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_stage_q <= sync_stage_d;
      sync_en_d_q  <= sync_en;
      sync_bus_q   <= sync_bus_d;
      pulse_q      <= en_rise;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sync_bus      = sync_bus_q;
  assign enable_pulse  = pulse_q;
  assign data_valid    = valid_q;
  assign overrun       = ovr_q;
  assign capture_count = cnt_q;

endmodule

// File: tb/tb_data_sync.sv
// Scoreboard bench for data_sync: each raised enable pushes the expected capture,
// and every enable_pulse pops and compares it. Directed checks cover valid/ack, overrun, wrap and async reset.
module tb_data_sync;

  logic       clk;
  logic       rst;
  logic [7:0] unsync_bus;
  logic       bus_enable;
  logic       data_ack;
  logic       ovr_clr;
  logic [7:0] sync_bus;
  logic       enable_pulse;
  logic       data_valid;
  logic       overrun;
  logic [7:0] capture_count;

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .unsync_bus    (unsync_bus),
    .bus_enable    (bus_enable),
    .data_ack      (data_ack),
    .ovr_clr       (ovr_clr),
    .sync_bus      (sync_bus),
    .enable_pulse  (enable_pulse),
    .data_valid    (data_valid),
    .overrun       (overrun),
    .capture_count (capture_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_count;
  int         tests_run;
  int         tests_failed;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input logic [7:0] d);
    unsync_bus = d;
    bus_enable = 1'b1;
    exp_count  = exp_count + 8'd1;
    sb_q.push_back('{data: d, cnt: exp_count});
  endtask

  task automatic drop();
    bus_enable = 1'b0;
    tick(4);
  endtask

  task automatic capture(input logic [7:0] d);
    drop();
    raise(d);
    tick(4);
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && enable_pulse) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_sync_bus", 32'(sync_bus), 32'(e.data));
        check_eq("sb_count", 32'(capture_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_count    = 8'd0;
    rst          = 1'b0;
    unsync_bus   = 8'h00;
    bus_enable   = 1'b0;
    data_ack     = 1'b0;
    ovr_clr      = 1'b0;

    tick(2);
    check_eq("rst_sync_bus", 32'(sync_bus), 32'h0);
    check_eq("rst_pulse", 32'(enable_pulse), 32'h0);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_count", 32'(capture_count), 32'h0);
    rst = 1'b1;
    tick(2);

    // First capture: pulse three edges after the first high sample, then none while held.
    raise(8'hA5);
    tick(1); check_eq("lat_edge1", 32'(enable_pulse), 32'h0);
    tick(1); check_eq("lat_edge2", 32'(enable_pulse), 32'h0);
    tick(1); check_eq("lat_edge3", 32'(enable_pulse), 32'h1);
    tick(6);
    check_eq("a5_data", 32'(sync_bus), 32'hA5);
    check_eq("a5_valid", 32'(data_valid), 32'h1);
    check_eq("a5_count", 32'(capture_count), 32'h1);

    pulse_ack();
    check_eq("ack_clears_valid", 32'(data_valid), 32'h0);
    capture(8'h3C);
    check_eq("3c_data", 32'(sync_bus), 32'h3C);
    check_eq("3c_count", 32'(capture_count), 32'h2);
    check_eq("3c_overrun", 32'(overrun), 32'h0);
    check_eq("3c_valid", 32'(data_valid), 32'h1);

    // Overrun set, clear, and set-wins-over-clear.
    pulse_ack();
    capture(8'h11);
    check_eq("11_overrun", 32'(overrun), 32'h0);
    capture(8'h22);
    check_eq("22_overrun", 32'(overrun), 32'h1);
    check_eq("22_data", 32'(sync_bus), 32'h22);
    pulse_clr();
    check_eq("ovr_clr", 32'(overrun), 32'h0);
    drop();
    raise(8'h33);
    tick(2);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check_eq("ovr_set_wins", 32'(overrun), 32'h1);

    pulse_clr();
    pulse_ack();
    check_eq("pre_ack_valid", 32'(data_valid), 32'h0);
    pulse_ack();
    check_eq("ack_idle_valid", 32'(data_valid), 32'h0);

    // Ack in the en_rise cycle, first with valid low, then with valid high.
    drop();
    raise(8'h44);
    tick(2);
    pulse_ack();
    check_eq("ack_rise_valid0", 32'(data_valid), 32'h1);
    check_eq("ack_rise_ovr0", 32'(overrun), 32'h0);
    drop();
    raise(8'h55);
    tick(2);
    pulse_ack();
    check_eq("ack_rise_valid1", 32'(data_valid), 32'h1);
    check_eq("ack_rise_ovr1", 32'(overrun), 32'h0);

    // 256 captures: counter returns to its starting value and passes through 0.
    for (int i = 0; i < 256; i++) begin
      capture(8'($urandom_range(0, 255)));
      if (exp_count == 8'h00) check_eq("wrap_zero", 32'(capture_count), 32'h0);
    end
    check_eq("wrap_full", 32'(capture_count), 32'h7);

    // Async reset with a pending 1 in the chain.
    capture(8'h77);
    drop();
    raise(8'h66);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_sync_bus", 32'(sync_bus), 32'h0);
    check_eq("arst_pulse", 32'(enable_pulse), 32'h0);
    check_eq("arst_valid", 32'(data_valid), 32'h0);
    check_eq("arst_overrun", 32'(overrun), 32'h0);
    check_eq("arst_count", 32'(capture_count), 32'h0);
    void'(sb_q.pop_back());
    exp_count = 8'd0;
    tick(3);
    check_eq("arst_no_pulse", 32'(enable_pulse), 32'h0);
    rst = 1'b1;
    exp_count = 8'd1;
    sb_q.push_back('{data: 8'h66, cnt: 8'd1});
    tick(1); check_eq("rel_edge1", 32'(enable_pulse), 32'h0);
    tick(1); check_eq("rel_edge2", 32'(enable_pulse), 32'h0);
    tick(1); check_eq("rel_edge3", 32'(enable_pulse), 32'h1);
    tick(5);
    check_eq("rel_count", 32'(capture_count), 32'h1);

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
